// File: rtl/nios_mem_pkg.sv
// Shared definitions for the NIOS on-chip memory loader: loader state encoding,
// default memory geometry and the byte-lane layout of a 32-bit memory word.
package nios_mem_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DEPTH  = 33000;
    localparam int DEFAULT_CNT_W  = 18;

    localparam int LANES  = 4;
    localparam int WORD_W = 8 * LANES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/nios_byte_packer.sv
// Packs a little-endian byte stream into one 32-bit word, tracking which lanes
// have been filled. Unfilled lanes always read back as zero.
module nios_byte_packer
    import nios_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [7:0]        push_data,
    input  logic              clear,
    output logic [WORD_W-1:0] word_data,
    output logic [LANES-1:0]  word_be,
    output logic              last_lane
);

    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [LANES-1:0]  be_q, be_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        lane_d = lane_q;
        data_d = data_q;
        be_d   = be_q;
        if (clear) begin
            lane_d = '0;
            data_d = '0;
            be_d   = '0;
        end else if (push) begin
            data_d[{lane_q, 3'b000} +: 8] = push_data;
            be_d[lane_q]                  = 1'b1;
            lane_d                        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments; reset is synchronous.
        if (reset) begin
            lane_q <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            be_q   <= be_d;
        end
    end

    assign word_data = data_q;
    assign word_be   = be_q;
    assign last_lane = (lane_q == 2'd3);

endmodule

// File: rtl/nios_mem_loader.sv
// Streams a byte-counted image into a NIOS on-chip memory port, one 32-bit word
// per single-cycle write, holding the CPU memory port frozen while busy.
module nios_mem_loader
    import nios_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Wide enough that base_addr + words can never wrap, whichever input is wider.
    localparam int CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_write_q, mem_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              byte_accept;
    logic              pack_push;
    logic              pack_clear;
    logic              last_lane;
    logic [31:0]       pack_data;
    logic [3:0]        pack_be;

    logic [CHK_W-1:0]  words_needed;
    logic [CHK_W-1:0]  end_addr;
    logic              range_bad;

    always_comb begin
        words_needed = (CHK_W'(byte_count) + CHK_W'(3)) >> 2;
        end_addr     = CHK_W'(base_addr) + words_needed;
        range_bad    = (end_addr > CHK_W'(DEPTH));
    end

    assign byte_accept = in_valid && in_ready_q;

    nios_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .push      (pack_push),
        .push_data (in_data),
        .clear     (pack_clear),
        .word_data (pack_data),
        .word_be   (pack_be),
        .last_lane (last_lane)
    );

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        in_ready_d  = 1'b0;
        mem_write_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b1;
        pack_push   = 1'b0;
        pack_clear  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (byte_count == '0) begin
                        state_d = ST_DONE;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                    end else if (range_bad) begin
                        error_d = 1'b1;
                    end else begin
                        state_d     = ST_COLLECT;
                        error_d     = 1'b0;
                        busy_d      = 1'b1;
                        in_ready_d  = 1'b1;
                        address_d   = base_addr;
                        remaining_d = byte_count;
                    end
                end
            end

            ST_COLLECT: begin
                in_ready_d = 1'b1;
                if (byte_accept) begin
                    pack_push   = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    // Word closes on its fourth byte or on the last byte of the image.
                    if (last_lane || (remaining_q == CNT_W'(1))) begin
                        state_d     = ST_WRITE;
                        in_ready_d  = 1'b0;
                        mem_write_d = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                pack_clear = 1'b1;
                address_d  = address_q + ADDR_W'(1);
                if (remaining_q != '0) begin
                    state_d    = ST_COLLECT;
                    in_ready_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            address_q   <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_address    = address_q;
    assign mem_byteenable = pack_be;
    assign mem_writedata  = pack_data;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_reset_req  = busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: doc/nios_mem_loader.md
NIOS_MEM_LOADER -- requirements
Module: nios_mem_loader

Interface
REQ-001 Parameter: ADDR_W, default 16, word-address width of the on-chip memory port.
REQ-002 Parameter: DEPTH, default 33000, number of 32-bit words in the target memory.
REQ-003 Parameter: CNT_W, default 18, width of the byte-count input.
REQ-004 Port: clk  in  1  single clock; all logic is rising-edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle load request; sampled only in IDLE.
REQ-007 Port: base_addr  in  ADDR_W  first word address of the load.
REQ-008 Port: byte_count  in  CNT_W  number of bytes to load.
REQ-009 Port: in_data  in  8  stream byte.
REQ-010 Port: in_valid  in  1  in_data is valid.
REQ-011 Port: in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-012 Port: mem_address  out  ADDR_W  word address to memory.
REQ-013 Port: mem_byteenable  out  4  byte lanes to write.
REQ-014 Port: mem_chipselect  out  1  memory select.
REQ-015 Port: mem_write  out  1  write strobe; single-cycle, no waitrequest.
REQ-016 Port: mem_writedata  out  32  assembled word.
REQ-017 Port: mem_reset_req  out  1  held high while busy to freeze memory clock-enable on the CPU port.
REQ-018 Port: busy  out  1  load in progress.
REQ-019 Port: done  out  1  one-cycle pulse on successful completion.
REQ-020 Port: error  out  1  sticky range error; cleared by the next accepted start or by reset.

Function
REQ-021 States SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-022 IDLE: on start, if byte_count == 0 -> DONE; else if base_addr + ceil(byte_count/4) > DEPTH -> set error, stay in IDLE, no writes; else -> COLLECT.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 COLLECT: in_ready = 1; each accepted byte goes to lane k (k = 0..3, little-endian, first byte in bits 7:0), k increments, remaining decrements.
REQ-025 COLLECT -> WRITE on the cycle a byte is accepted that makes k == 4 or remaining == 0.
REQ-026 WRITE: in_ready = 0; mem_chipselect = mem_write = 1 for exactly one cycle; byteenable bit i = 1 only for filled lanes; unfilled lanes of writedata = 0.
REQ-027 Write latency: mem_write asserts the cycle after the completing byte is accepted.
REQ-028 After WRITE: address increments by 1, k clears; -> COLLECT if remaining > 0, else -> DONE.
REQ-029 DONE: done = 1 for one cycle, -> IDLE.
REQ-030 busy = 1 in COLLECT, WRITE, DONE; mem_reset_req = busy.
REQ-031 in_valid low in COLLECT SHALL stall without timeout; partially filled lanes are held.
REQ-032 Address arithmetic SHALL be ADDR_W+1 bits for the range check, so base_addr + words overflow is detected, not wrapped.
REQ-033 mem_chipselect and mem_write SHALL be 0 in every state other than WRITE.

Reset
REQ-034 Reset SHALL force IDLE; in_ready, mem_write, mem_chipselect, mem_byteenable, mem_reset_req, busy, done, error = 0; mem_address, mem_writedata = 0.
REQ-035 Reset mid-load SHALL abandon the partial word with no write issued; already-written words remain in memory.

Structure
REQ-036 State encoding enum and the DEPTH/ADDR_W defaults SHALL live in the shared package nios_mem_pkg.
REQ-037 Byte-to-word packing (lane counter, data/byteenable registers) SHALL be one sub-module, nios_byte_packer; FSM and counters stay in the top.

Verification
REQ-038 base 0x0010, count 8, bytes 01..08 -> writes @0x0010 data 0x04030201 be 0xF, @0x0011 data 0x08070605 be 0xF, done pulse.
REQ-039 base 0x0000, count 6, bytes AA BB CC DD EE FF -> @0x0000 0xDDCCBBAA be 0xF, @0x0001 0x0000FFEE be 0x3.
REQ-040 base 32996, count 20 (5 words) -> error = 1, no mem_write, busy stays 0; base 32995, count 20 -> five writes, last @32999, no error.
REQ-041 count 0 -> no writes, busy high one cycle, done pulse; in_valid gaps of 3 cycles between bytes -> identical writes to REQ-038.
REQ-042 Reset asserted after 2 bytes of word 1 -> no mem_write, all outputs at reset values next cycle; start during busy -> ignored.
